// File: rtl/pipeline_pkg.sv
// Shared pipeline types and helpers for the branch predictor.
// Entry layout and counter reset/allocate values live here.
package pipeline_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CTR_W = 4;

  typedef struct packed {
    logic                valid;
    logic [XLEN_DEF-1:0] tag;
    logic [CTR_W-1:0]    ctr;
    logic [XLEN_DEF-1:0] target;
  } bpuEntry_t;

  function automatic logic [CTR_W-1:0] ctrWeakTaken(
    input int bits
  );
    return CTR_W'(1 << (bits - 1));
  endfunction

  function automatic logic [CTR_W-1:0] ctrWeakNotTaken(
    input int bits
  );
    return CTR_W'((1 << (bits - 1)) - 1);
  endfunction

endpackage

// File: rtl/bpu_sat_counter.sv
// Next-state logic for one saturating direction counter.
// Counter lives in a CTR_W-wide field; only CTR_BITS are ever set.
module bpu_sat_counter
  import pipeline_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic             inc,
  input  logic             dec,
  input  logic             forceMax,
  input  logic             init,
  input  logic [CTR_W-1:0] cur,
  output logic [CTR_W-1:0] nxt
);

  localparam logic [CTR_W-1:0] MAX =
    CTR_W'((1 << CTR_BITS) - 1);

  always_comb begin
    nxt = cur;
    unique case (1'b1)
      forceMax: nxt = MAX;
      init:     nxt = ctrWeakTaken(CTR_BITS);
      inc:      if (cur != MAX) nxt = cur + 1'b1;
      dec:      if (cur != '0) nxt = cur - 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with per-entry saturating counters.
// Lookup in IF is combinational; update arrives from ID.
module branch_predict_unit
  import pipeline_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int XLEN     = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int IDX = $clog2(ENTRIES);

  bpuEntry_t tbl [ENTRIES];

  logic [IDX-1:0]   lIdx;
  logic [IDX-1:0]   uIdx;
  logic [XLEN-1:0]  lTag;
  logic [XLEN-1:0]  uTag;
  logic             lHit;
  logic             uHit;
  bpuEntry_t        uEnt;
  bpuEntry_t        newEnt;
  logic             writeEn;
  logic [CTR_W-1:0] ctrNext;

  assign lIdx = lookup_pc[IDX+1:2];
  assign lTag = lookup_pc >> (IDX + 2);
  assign lHit = tbl[lIdx].valid &&
                (tbl[lIdx].tag == lTag);

  assign pred_hit    = lHit;
  assign pred_taken  = lHit &
                       tbl[lIdx].ctr[CTR_BITS-1];
  assign pred_target = pred_taken ?
                       tbl[lIdx].target :
                       lookup_pc + XLEN'(4);

  assign mispredict = upd_valid &&
    ((upd_taken != upd_pred_taken) ||
     (upd_taken && (upd_target != upd_pred_target)));

  assign redirect_pc = upd_taken ? upd_target :
                       upd_pc + XLEN'(4);

  assign uIdx = upd_pc[IDX+1:2];
  assign uTag = upd_pc >> (IDX + 2);
  assign uEnt = tbl[uIdx];
  assign uHit = uEnt.valid && (uEnt.tag == uTag);

  bpu_sat_counter #(
    .CTR_BITS(CTR_BITS)
  ) uCtr (
    .inc     (upd_valid & uHit & upd_taken &
              ~upd_is_jump),
    .dec     (upd_valid & uHit & ~upd_taken &
              ~upd_is_jump),
    .forceMax(upd_valid & upd_is_jump),
    .init    (upd_valid & ~uHit & upd_taken &
              ~upd_is_jump),
    .cur     (uEnt.ctr),
    .nxt     (ctrNext)
  );

  // Not-taken misses never allocate.
  assign writeEn = upd_valid &
                   (uHit | upd_taken | upd_is_jump);

  always_comb begin
    newEnt        = uEnt;
    newEnt.valid  = 1'b1;
    newEnt.tag    = uTag;
    newEnt.ctr    = ctrNext;
    if (upd_taken || upd_is_jump)
      newEnt.target = upd_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '{
          valid:  1'b0,
          tag:    '0,
          ctr:    ctrWeakNotTaken(CTR_BITS),
          target: '0
        };
      end
    end else if (writeEn) begin
      tbl[uIdx] <= newEnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (upd_valid && (branch_cnt != '1))
        branch_cnt <= branch_cnt + 1'b1;
      if (mispredict && (mispred_cnt != '1))
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench: two predictor configs share one stimulus.
// Config A is 16x2-bit, config B is 64x3-bit.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookupPc;
  logic        updValid;
  logic [31:0] updPc;
  logic        updIsJump;
  logic        updTaken;
  logic [31:0] updTarget;
  logic        updPredTaken;
  logic [31:0] updPredTarget;

  logic        hitA, takenA, misA;
  logic [31:0] tgtA, redA, bcA, mcA;
  logic        hitB, takenB, misB;
  logic [31:0] tgtB, redB, bcB, mcB;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  localparam int S_HIT = 0;
  localparam int S_TKN = 1;
  localparam int S_TGT = 2;
  localparam int S_MIS = 3;
  localparam int S_RED = 4;
  localparam int S_BC  = 5;
  localparam int S_MC  = 6;

  always #5 clk = ~clk;

  branch_predict_unit #(
    .ENTRIES(16), .CTR_BITS(2), .XLEN(32)
  ) dutA (
    .clk(clk), .reset(reset),
    .lookup_pc(lookupPc),
    .pred_hit(hitA), .pred_taken(takenA),
    .pred_target(tgtA),
    .upd_valid(updValid), .upd_pc(updPc),
    .upd_is_jump(updIsJump),
    .upd_taken(updTaken),
    .upd_target(updTarget),
    .upd_pred_taken(updPredTaken),
    .upd_pred_target(updPredTarget),
    .mispredict(misA), .redirect_pc(redA),
    .branch_cnt(bcA), .mispred_cnt(mcA)
  );

  branch_predict_unit #(
    .ENTRIES(64), .CTR_BITS(3), .XLEN(32)
  ) dutB (
    .clk(clk), .reset(reset),
    .lookup_pc(lookupPc),
    .pred_hit(hitB), .pred_taken(takenB),
    .pred_target(tgtB),
    .upd_valid(updValid), .upd_pc(updPc),
    .upd_is_jump(updIsJump),
    .upd_taken(updTaken),
    .upd_target(updTarget),
    .upd_pred_taken(updPredTaken),
    .upd_pred_target(updPredTarget),
    .mispredict(misB), .redirect_pc(redB),
    .branch_cnt(bcB), .mispred_cnt(mcB)
  );

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_HIT:      return {31'd0, hitA};
      S_TKN:      return {31'd0, takenA};
      S_TGT:      return tgtA;
      S_MIS:      return {31'd0, misA};
      S_RED:      return redA;
      S_BC:       return bcA;
      S_MC:       return mcA;
      10 + S_HIT: return {31'd0, hitB};
      10 + S_TKN: return {31'd0, takenB};
      10 + S_TGT: return tgtB;
      10 + S_MIS: return {31'd0, misB};
      10 + S_RED: return redB;
      10 + S_BC:  return bcB;
      10 + S_MC:  return mcB;
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic checkEq(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h",
               tag, got, want);
    end
  endtask

  task automatic expect2(
    input string tag, input int sel,
    input logic [31:0] va,
    input logic [31:0] vb
  );
    sb.push_back('{{"A.", tag}, sel, va});
    sb.push_back('{{"B.", tag}, sel + 10, vb});
  endtask

  task automatic expectBoth(
    input string tag, input int sel,
    input logic [31:0] v
  );
    expect2(tag, sel, v, v);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkEq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic upd(
    input logic v, input logic [31:0] pc,
    input logic j, input logic t,
    input logic [31:0] tgt,
    input logic pt, input logic [31:0] ptg
  );
    updValid      = v;
    updPc         = pc;
    updIsJump     = j;
    updTaken      = t;
    updTarget     = tgt;
    updPredTaken  = pt;
    updPredTarget = ptg;
  endtask

  task automatic idle();
    upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,
        1'b0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    lookupPc = 32'h0040_0010;
    upd(1'b1, 32'h0040_0010, 1'b0, 1'b1,
        32'h0040_0040, 1'b0, 32'h0040_0014);
    step();
    step();
    reset = 1'b0;
    idle();
    expectBoth("rst_hit", S_HIT, 0);
    expectBoth("rst_tkn", S_TKN, 0);
    expectBoth("rst_tgt", S_TGT, 32'h0040_0014);
    expectBoth("rst_bc", S_BC, 0);
    expectBoth("rst_mc", S_MC, 0);
    expectBoth("rst_mis", S_MIS, 0);
    drain();

    upd(1'b1, 32'h0040_0010, 1'b0, 1'b1,
        32'h0040_0040, 1'b0, 32'h0040_0014);
    expectBoth("alloc_mis", S_MIS, 1);
    expectBoth("alloc_red", S_RED, 32'h0040_0040);
    expectBoth("same_idx_old", S_HIT, 0);
    drain();
    step();
    idle();
    expectBoth("alloc_hit", S_HIT, 1);
    expectBoth("alloc_tkn", S_TKN, 1);
    expectBoth("alloc_tgt", S_TGT, 32'h0040_0040);
    expectBoth("alloc_bc", S_BC, 1);
    expectBoth("alloc_mc", S_MC, 1);
    drain();

    for (int i = 0; i < 4; i++) begin
      upd(1'b1, 32'h0040_0010, 1'b0, 1'b1,
          32'h0040_0040, 1'b1, 32'h0040_0040);
      expectBoth("good_mis", S_MIS, 0);
      drain();
      step();
    end
    idle();
    expectBoth("sat_tkn", S_TKN, 1);
    expectBoth("sat_bc", S_BC, 5);
    expectBoth("sat_mc", S_MC, 1);
    drain();

    upd(1'b1, 32'h0040_0010, 1'b0, 1'b0,
        32'h0, 1'b1, 32'h0040_0040);
    expectBoth("nt_mis", S_MIS, 1);
    expectBoth("nt_red", S_RED, 32'h0040_0014);
    drain();
    step();
    idle();
    expectBoth("dec1_tkn", S_TKN, 1);
    expectBoth("dec1_tgt", S_TGT, 32'h0040_0040);
    expectBoth("dec1_bc", S_BC, 6);
    expectBoth("dec1_mc", S_MC, 2);
    drain();

    upd(1'b1, 32'h0040_0010, 1'b0, 1'b0,
        32'h0, 1'b1, 32'h0040_0040);
    step();
    idle();
    expectBoth("dec2_hit", S_HIT, 1);
    expect2("dec2_tkn", S_TKN, 0, 1);
    expect2("dec2_tgt", S_TGT,
            32'h0040_0014, 32'h0040_0040);
    expectBoth("dec2_bc", S_BC, 7);
    expectBoth("dec2_mc", S_MC, 3);
    drain();

    upd(1'b1, 32'h0040_0020, 1'b0, 1'b0,
        32'h0, 1'b0, 32'h0040_0024);
    expectBoth("ntmiss_mis", S_MIS, 0);
    drain();
    step();
    idle();
    lookupPc = 32'h0040_0020;
    expectBoth("noalloc_hit", S_HIT, 0);
    expectBoth("noalloc_bc", S_BC, 8);
    drain();

    upd(1'b1, 32'h0040_0110, 1'b0, 1'b1,
        32'h0040_0200, 1'b0, 32'h0040_0114);
    expectBoth("alias_mis", S_MIS, 1);
    drain();
    step();
    idle();
    lookupPc = 32'h0040_0010;
    expectBoth("alias_old_hit", S_HIT, 0);
    drain();
    lookupPc = 32'h0040_0110;
    expectBoth("alias_new_hit", S_HIT, 1);
    expectBoth("alias_new_tkn", S_TKN, 1);
    expectBoth("alias_new_tgt", S_TGT, 32'h0040_0200);
    expectBoth("alias_bc", S_BC, 9);
    expectBoth("alias_mc", S_MC, 4);
    drain();

    upd(1'b1, 32'h0040_0030, 1'b1, 1'b1,
        32'h0040_0300, 1'b0, 32'h0040_0034);
    expectBoth("jmp_mis", S_MIS, 1);
    drain();
    step();
    idle();
    lookupPc = 32'h0040_0030;
    expectBoth("jmp_hit", S_HIT, 1);
    expectBoth("jmp_tkn", S_TKN, 1);
    expectBoth("jmp_tgt", S_TGT, 32'h0040_0300);
    expectBoth("jmp_bc", S_BC, 10);
    expectBoth("jmp_mc", S_MC, 5);
    drain();

    upd(1'b1, 32'h0040_0030, 1'b0, 1'b1,
        32'h0040_0300, 1'b1, 32'h0040_0304);
    expectBoth("badtgt_mis", S_MIS, 1);
    expectBoth("badtgt_red", S_RED, 32'h0040_0300);
    drain();
    step();
    upd(1'b1, 32'h0040_0030, 1'b0, 1'b0,
        32'h0, 1'b1, 32'h0040_0300);
    expectBoth("jnt_red", S_RED, 32'h0040_0034);
    drain();
    step();
    idle();
    expectBoth("jmax_tkn", S_TKN, 1);
    expectBoth("jmax_bc", S_BC, 12);
    expectBoth("jmax_mc", S_MC, 7);
    drain();

    lookupPc = 32'hFFFF_FFFC;
    upd(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0,
        32'h0, 1'b1, 32'h0000_0010);
    expectBoth("wrap_hit", S_HIT, 0);
    expectBoth("wrap_tgt", S_TGT, 32'h0);
    expectBoth("wrap_mis", S_MIS, 1);
    expectBoth("wrap_red", S_RED, 32'h0);
    drain();
    step();
    idle();
    expectBoth("wrap_bc", S_BC, 13);
    expectBoth("wrap_mc", S_MC, 8);
    drain();

    upd(1'b0, 32'h0040_0110, 1'b0, 1'b0,
        32'h0, 1'b1, 32'h0000_0010);
    lookupPc = 32'h0040_0110;
    expectBoth("inv_mis", S_MIS, 0);
    drain();
    step();
    expectBoth("inv_hit", S_HIT, 1);
    expectBoth("inv_tkn", S_TKN, 1);
    expectBoth("inv_tgt", S_TGT, 32'h0040_0200);
    expectBoth("inv_bc", S_BC, 13);
    expectBoth("inv_mc", S_MC, 8);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
